// File: rtl/data_ram_arbiter.sv
// Two-master arbiter for the single data_ram port: master 0 (core) has priority, master 1
// (debug/DMA loader) gets a starvation guard and a lock for uninterrupted bursts.
module data_ram_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_sel,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_sel,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,

  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  typedef enum logic [0:0] {StArb, StLock1} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        starve;

  logic        m0_rvalid_q, m1_rvalid_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;

  assign starve = (wait_cnt_q == MaxWait);

  // Grants and next state
  always_comb begin
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    state_d = state_q;

    if (!rst) begin
      unique case (state_q)
        StArb: begin
          m1_gnt = m1_req & (~m0_req | starve);
          m0_gnt = m0_req & ~m1_gnt;
          if (m1_gnt && m1_lock) begin
            state_d = StLock1;
          end
        end
        StLock1: begin
          // m0 stays blocked even if m1 drops its request while holding the lock.
          m1_gnt = m1_req;
          if (!m1_lock) begin
            state_d = StArb;
          end
        end
        default: state_d = StArb;
      endcase
    end
  end

  // Starvation counter: consecutive cycles m1 was requesting but denied
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == StLock1 || !m1_req || m1_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < MaxWait) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // RAM port mux; idle port drives all zeros
  always_comb begin
    ram_we_o   = 1'b0;
    ram_sel_o  = 4'h0;
    ram_addr_o = '0;
    ram_data_o = 32'h0;
    if (m1_gnt) begin
      ram_we_o   = m1_we;
      ram_sel_o  = m1_sel;
      ram_addr_o = m1_addr;
      ram_data_o = m1_wdata;
    end else if (m0_gnt) begin
      ram_we_o   = m0_we;
      ram_sel_o  = m0_sel;
      ram_addr_o = m0_addr;
      ram_data_o = m0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StArb;
      wait_cnt_q  <= 4'd0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m1_rdata_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      m0_rvalid_q <= m0_gnt & ~m0_we;
      m1_rvalid_q <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) begin
        m0_rdata_q <= ram_data_i;
      end
      if (m1_gnt && !m1_we) begin
        m1_rdata_q <= ram_data_i;
      end
    end
  end

  // A read granted just before reset must not surface while reset is asserted.
  assign m0_rvalid = m0_rvalid_q & ~rst;
  assign m1_rvalid = m1_rvalid_q & ~rst;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed-vector bench for data_ram_arbiter with a byte-lane data_ram model attached.
module tb_data_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [3:0]  m0_sel;
  logic [11:0] m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [3:0]  m1_sel;
  logic [11:0] m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic        ram_we_o;
  logic [3:0]  ram_sel_o;
  logic [11:0] ram_addr_o;
  logic [31:0] ram_data_o, ram_data_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;

  data_ram_arbiter #(.ADDR_W(12), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_sel     (m0_sel),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_sel     (m1_sel),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_lock    (m1_lock),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .ram_we_o   (ram_we_o),
    .ram_sel_o  (ram_sel_o),
    .ram_addr_o (ram_addr_o),
    .ram_data_o (ram_data_o),
    .ram_data_i (ram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_ram model: asynchronous read, byte-lane write committed at the clock edge
  logic [31:0] mem [0:1023];
  logic        mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (ram_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_sel_o[b]) mem[ram_addr_o[11:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
      end
    end
  end

  assign ram_data_i = mem[ram_addr_o[11:2]];

  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  sel;
    logic [11:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        rst;
    req_t        a;
    req_t        b;
    logic        lock;
    logic        g0, g1, rv0, rv1;
    logic [31:0] rdata;
    logic        we;
    logic [11:0] addr;
  } vec_t;

  vec_t vecs[$];

  function automatic req_t idle();
    req_t r;
    r = '{req: 1'b0, we: 1'b0, sel: 4'h0, addr: 12'h0, wdata: 32'h0};
    return r;
  endfunction

  function automatic req_t rd(input logic [11:0] addr);
    req_t r;
    r = '{req: 1'b1, we: 1'b0, sel: 4'hF, addr: addr, wdata: 32'h0};
    return r;
  endfunction

  function automatic req_t wr(input logic [3:0] sel, input logic [11:0] addr,
                              input logic [31:0] data);
    req_t r;
    r = '{req: 1'b1, we: 1'b1, sel: sel, addr: addr, wdata: data};
    return r;
  endfunction

  task automatic add(input logic r, input req_t a, input req_t b, input logic lock,
                     input logic g0, input logic g1, input logic rv0, input logic rv1,
                     input logic [31:0] rdata, input logic we, input logic [11:0] addr);
    vec_t v;
    v.rst = r; v.a = a; v.b = b; v.lock = lock;
    v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1;
    v.rdata = rdata; v.we = we; v.addr = addr;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst      = v.rst;
    m0_req   = v.a.req;  m0_we = v.a.we;  m0_sel = v.a.sel;
    m0_addr  = v.a.addr; m0_wdata = v.a.wdata;
    m1_req   = v.b.req;  m1_we = v.b.we;  m1_sel = v.b.sel;
    m1_addr  = v.b.addr; m1_wdata = v.b.wdata;
    m1_lock  = v.lock;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got 0x%h, expected 0x%h", name, cur, act, exp);
    end
  endtask

  localparam logic [31:0] A0 = 32'h1111_0000;
  localparam logic [31:0] A1 = 32'h2222_0001;
  localparam logic [31:0] A2 = 32'h3333_0002;
  localparam logic [31:0] A3 = 32'h4444_0003;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  int cnt;

  initial begin
    rst = 1'b1; mem_clr = 1'b1; m1_lock = 1'b0;
    m0_req = 0; m0_we = 0; m0_sel = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_sel = 0; m1_addr = 0; m1_wdata = 0;

    // Reset; the write offered during reset must not reach the RAM
    add(1, idle(), idle(), 0, 0, 0, 0, 0, 0, 0, 12'h000);
    add(1, wr(4'hF, 12'h030, 32'hAAAA_5555), idle(), 0, 0, 0, 0, 0, 0, 0, 12'h000);
    for (int i = 0; i < 3; i++) add(0, idle(), idle(), 0, 0, 0, 0, 0, 0, 0, 12'h000);
    // m0 write then read back
    add(0, wr(4'hF, 12'h010, DB), idle(), 0, 1, 0, 0, 0, 0, 1, 12'h010);
    add(0, rd(12'h010), idle(), 0, 1, 0, 0, 0, 0, 0, 12'h010);
    add(0, idle(), idle(), 0, 0, 0, 1, 0, DB, 0, 12'h000);
    add(0, idle(), idle(), 0, 0, 0, 0, 0, 0, 0, 12'h000);
    // Starvation: m1 denied 4 cycles, wins the 5th, pattern repeats
    add(0, rd(12'h010), rd(12'h030), 0, 1, 0, 0, 0, 0, 0, 12'h010);
    for (int i = 0; i < 3; i++) add(0, rd(12'h010), rd(12'h030), 0, 1, 0, 1, 0, DB, 0, 12'h010);
    add(0, rd(12'h010), rd(12'h030), 0, 0, 1, 1, 0, DB, 0, 12'h030);
    add(0, rd(12'h010), rd(12'h030), 0, 1, 0, 0, 1, 32'h0, 0, 12'h010);
    for (int i = 0; i < 3; i++) add(0, rd(12'h010), rd(12'h030), 0, 1, 0, 1, 0, DB, 0, 12'h010);
    add(0, rd(12'h010), rd(12'h030), 0, 0, 1, 1, 0, DB, 0, 12'h030);
    add(0, idle(), idle(), 0, 0, 0, 0, 1, 32'h0, 0, 12'h000);
    // Locked m1 burst while m0 keeps requesting, including a locked gap with no m1 request
    add(0, idle(), wr(4'hF, 12'h100, A0), 1, 0, 1, 0, 0, 0, 1, 12'h100);
    add(0, rd(12'h104), wr(4'hF, 12'h104, A1), 1, 0, 1, 0, 0, 0, 1, 12'h104);
    add(0, rd(12'h104), idle(), 1, 0, 0, 0, 0, 0, 0, 12'h000);
    add(0, rd(12'h104), wr(4'hF, 12'h108, A2), 1, 0, 1, 0, 0, 0, 1, 12'h108);
    add(0, rd(12'h104), wr(4'hF, 12'h10C, A3), 0, 0, 1, 0, 0, 0, 1, 12'h10C);
    add(0, rd(12'h104), idle(), 0, 1, 0, 0, 0, 0, 0, 12'h104);
    add(0, idle(), idle(), 0, 0, 0, 1, 0, A1, 0, 12'h000);
    // Byte select: low two lanes only
    add(0, idle(), wr(4'hF, 12'h020, 32'hFFFF_FFFF), 0, 0, 1, 0, 0, 0, 1, 12'h020);
    add(0, idle(), wr(4'h3, 12'h020, 32'h1122_3344), 0, 0, 1, 0, 0, 0, 1, 12'h020);
    add(0, idle(), rd(12'h020), 0, 0, 1, 0, 0, 0, 0, 12'h020);
    add(0, idle(), idle(), 0, 0, 0, 0, 1, 32'hFFFF_3344, 0, 12'h000);
    // Back-to-back reads to different masters give independent rvalid pulses
    add(0, rd(12'h010), idle(), 0, 1, 0, 0, 0, 0, 0, 12'h010);
    add(0, idle(), rd(12'h100), 0, 0, 1, 1, 0, DB, 0, 12'h100);
    add(0, idle(), idle(), 0, 0, 0, 0, 1, A0, 0, 12'h000);
    // Reset mid-read with wait_cnt at 4: rvalid suppressed, counter cleared
    add(0, rd(12'h104), rd(12'h108), 0, 1, 0, 0, 0, 0, 0, 12'h104);
    for (int i = 0; i < 3; i++) add(0, rd(12'h104), rd(12'h108), 0, 1, 0, 1, 0, A1, 0, 12'h104);
    add(1, rd(12'h104), rd(12'h108), 0, 0, 0, 0, 0, 0, 0, 12'h000);
    add(0, rd(12'h104), rd(12'h108), 0, 1, 0, 0, 0, 0, 0, 12'h104);
    // Reset while locked returns to arbitration
    add(0, idle(), wr(4'hF, 12'h040, 32'h5), 1, 0, 1, 1, 0, A1, 1, 12'h040);
    add(1, rd(12'h040), idle(), 1, 0, 0, 0, 0, 0, 0, 12'h000);
    add(0, rd(12'h040), idle(), 0, 1, 0, 0, 0, 0, 0, 12'h040);
    add(0, idle(), idle(), 0, 0, 0, 1, 0, 32'h5, 0, 12'h000);

    @(posedge clk);
    #1 mem_clr = 1'b0;

    foreach (vecs[k]) begin
      cur = k;
      drive(vecs[k]);
      @(negedge clk);
      chk("m0_gnt", 32'(m0_gnt), 32'(vecs[k].g0));
      chk("m1_gnt", 32'(m1_gnt), 32'(vecs[k].g1));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(vecs[k].rv0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(vecs[k].rv1));
      chk("ram_we_o", 32'(ram_we_o), 32'(vecs[k].we));
      chk("ram_addr_o", 32'(ram_addr_o), 32'(vecs[k].addr));
      if (vecs[k].rv0) chk("m0_rdata", m0_rdata, vecs[k].rdata);
      if (vecs[k].rv1) chk("m1_rdata", m1_rdata, vecs[k].rdata);
      @(posedge clk);
      #1;
    end

    // rdata retention after rvalid drops; m1_rdata was cleared by the earlier reset
    cur = 1000;
    drive(vecs[0]);
    rst = 1'b0;
    @(negedge clk);
    chk("m0_rvalid_idle", 32'(m0_rvalid), 32'h0);
    chk("m0_rdata_hold", m0_rdata, 32'h5);
    chk("m1_rdata_after_rst", m1_rdata, 32'h0);
    @(posedge clk);
    #1;

    // Count denied cycles before m1 wins, bounded
    cur = 1001;
    m0_req = 1; m0_we = 0; m0_addr = 12'h010;
    m1_req = 1; m1_we = 0; m1_addr = 12'h030;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      if (m1_gnt) break;
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("starve_denied_cycles", 32'(cnt), 32'd4);
    chk("starve_m0_blocked", 32'(m0_gnt), 32'h0);
    @(posedge clk);
    #1;
    m0_req = 0; m1_req = 0;
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single data_ram port between two requesters: master 0 (core load/store port, high priority) and master 1 (debug/DMA loader that preloads or inspects data memory).
- Sits between risc_v / loader and data_ram.
- Issues at most one RAM access per cycle. Provides a starvation guard for master 1 and a lock so master 1 can perform uninterrupted multi-word transfers.

Parameters:
- ADDR_W, 12, byte address width of the RAM port (matches data_ram addr_i).
- MAX_WAIT, 4, consecutive denied cycles after which master 1 wins over master 0 (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  master 0 access request
- m0_we  in  1  master 0 write enable (1 = write, 0 = read)
- m0_sel  in  4  master 0 byte lane select
- m0_addr  in  ADDR_W  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_gnt  out  1  master 0 access issued this cycle
- m0_rvalid  out  1  master 0 read data valid
- m0_rdata  out  32  master 0 read data
- m1_req, m1_we, m1_sel, m1_addr, m1_wdata  in  1/1/4/ADDR_W/32  master 1 request fields
- m1_lock  in  1  hold ownership after the current master 1 grant
- m1_gnt  out  1  master 1 access issued this cycle
- m1_rvalid  out  1  master 1 read data valid
- m1_rdata  out  32  master 1 read data
- ram_we_o  out  1  to data_ram we_i
- ram_sel_o  out  4  to data_ram sel_i
- ram_addr_o  out  ADDR_W  to data_ram addr_i
- ram_data_o  out  32  to data_ram data_i
- ram_data_i  in  32  from data_ram data_o; asynchronous read, valid in the same cycle as ram_addr_o

Behaviour:
- Clocking: single clock clk; rst synchronous, active-high, sampled on the rising edge.
- Reset state:
  - state = ARB, wait_cnt = 0.
  - m0_rvalid = m1_rvalid = 0; m0_rdata = m1_rdata = 0.
  - While rst = 1: m0_gnt = m1_gnt = 0 and all ram_*_o = 0.
- Grant timing: grants are combinational from the current requests and registered state. A granted request is presented on ram_*_o in the same cycle.
- Write commit: a write commits at the next rising edge.
- Read return: for a granted read, ram_data_i is registered. mX_rvalid = 1 and mX_rdata = data occur exactly one cycle after the grant. rvalid is a 1-cycle pulse, and is never asserted for writes.
- rdata retention: mX_rdata holds its last value when rvalid = 0.
- Idle RAM port: when no grant, ram_we_o = 0, ram_sel_o = 0, ram_addr_o = 0, ram_data_o = 0.
- State ARB:
  - Normally m0 has priority: m0_gnt = m0_req.
  - m1_gnt = m1_req & (~m0_req | starve), where starve = (wait_cnt == MAX_WAIT).
  - When starve and both request, m1 wins and m0_gnt = 0.
  - Transition to LOCK1 when m1_gnt & m1_lock.
- State LOCK1:
  - m0_gnt = 0 unconditionally.
  - m1_gnt = m1_req.
  - Return to ARB at the edge where m1_lock = 0. The grant in that cycle, if any, is still given.
  - m1_req may drop while locked; the lock is retained and m0 stays blocked.
- wait_cnt (4-bit):
  - Increments when m1_req & ~m1_gnt, saturating at MAX_WAIT.
  - Clears on m1_gnt or when m1_req = 0.
  - Held at 0 in LOCK1.
- Handshake: a master holds req and all fields stable until it sees gnt; fields are sampled only in the grant cycle. After gnt, the master may issue a new request in the next cycle (back-to-back, one access per cycle).
- Simultaneous events:
  - A read by m0 and a read by m1 are never granted in the same cycle.
  - A read grant in cycle N followed by a grant to the other master in cycle N+1 yields independent rvalid pulses in N+1 and N+2.
- Reset mid-operation:
  - A read granted in the cycle before rst rises produces no rvalid; it is discarded at the reset edge.
  - A write granted in the same cycle as rst = 1 is not issued, because grants are forced to 0.
  - LOCK1 is exited.

Test Plan:
- Reset, no requests: hold rst 2 cycles, then idle 3 cycles -> all gnt/rvalid = 0, ram_we_o = 0, ram_addr_o = 0.
- m0 write then read: m0 writes 0xDEADBEEF with sel = 0xF to addr 0x010; next cycle m0 reads addr 0x010 -> m0_gnt in both cycles, m0_rvalid = 1 one cycle after the read grant with m0_rdata = 0xDEADBEEF, m1_rvalid = 0.
- Starvation, MAX_WAIT = 4: m0_req and m1_req held high continuously -> m1 denied 4 cycles, then m1_gnt = 1 on the 5th cycle with m0_gnt = 0, then the pattern repeats.
- Lock burst: m1 writes 4 words with m1_lock = 1, 0x100..0x10C, while m0_req is held high -> m0_gnt = 0 for all 4 cycles. m1_lock drops on the 4th word, and m0_gnt = 1 the cycle after. m0 readback of 0x104 returns the m1 data.
- Byte select: m1 writes 0x11223344 with sel = 0x3 over 0xFFFFFFFF at addr 0x020 -> a later read returns 0xFFFF3344, assuming sel bit0 = byte 0.
- Reset mid-read: m0 read granted in cycle N, rst = 1 in cycle N+1 -> m0_rvalid = 0 in N+1; the state after reset is ARB with wait_cnt = 0.
